// File: rtl/menu_controller.sv
// menu_controller
//
// Game menu sequencer: main song menu, 3-2-1 countdown, play, and pause menu.
// Buttons are debounced levels; each one acts only on its rising edge.
// All outputs are registered and reflect the state entered on the clock
// edge at which the triggering input was sampled.
//
// Ports
//   clk65        65 MHz pixel clock, rising edge
//   reset        synchronous, active-high
//   frame_tick   one-cycle pulse per video frame
//   btn_up/down/select/pause  debounced button levels
//   song_done    one-cycle pulse, current song finished
//   pause        menu overlay enable
//   menu_page    0 = main menu, 1 = pause menu
//   cursor       highlighted menu item
//   song_sel     song index latched for the game datapath
//   game_run     high while notes advance
//   countdown    seconds left before play (3..1), 0 otherwise
//   start_pulse  one-cycle strobe, song started from main menu
//   quit_pulse   one-cycle strobe, song quit from pause menu
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_MAIN      | main menu, choosing a song
// ST_COUNTDOWN | 3-2-1 lead-in, COUNT_FRAMES frames per step
// ST_PLAYING   | song running, notes advance
// ST_PAUSED    | pause menu (0 = Resume, 1 = Quit)

module menu_controller #(
    parameter int NUM_SONGS    = 4,
    parameter int COUNT_FRAMES = 60
) (
    input  logic       clk65,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_select,
    input  logic       btn_pause,
    input  logic       song_done,
    output logic       pause,
    output logic       menu_page,
    output logic [1:0] cursor,
    output logic [1:0] song_sel,
    output logic       game_run,
    output logic [1:0] countdown,
    output logic       start_pulse,
    output logic       quit_pulse
);

    localparam int FW = (COUNT_FRAMES > 1) ? $clog2(COUNT_FRAMES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(COUNT_FRAMES - 1);
    localparam logic [1:0]    LAST_SONG  = 2'(NUM_SONGS - 1);

    localparam logic [1:0] ST_MAIN      = 2'd0;
    localparam logic [1:0] ST_COUNTDOWN = 2'd1;
    localparam logic [1:0] ST_PLAYING   = 2'd2;
    localparam logic [1:0] ST_PAUSED    = 2'd3;

    logic [1:0]    state;
    logic [FW-1:0] fcnt;
    logic          up_q;
    logic          down_q;
    logic          sel_q;
    logic          pause_q;

    logic          up_e;
    logic          down_e;
    logic          sel_e;
    logic          pause_e;

    logic [1:0]    nxt_state;
    logic [FW-1:0] nxt_fcnt;
    logic [1:0]    nxt_cursor;
    logic [1:0]    nxt_song_sel;
    logic [1:0]    nxt_countdown;
    logic          nxt_start;
    logic          nxt_quit;

    assign up_e    = btn_up     & ~up_q;
    assign down_e  = btn_down   & ~down_q;
    assign sel_e   = btn_select & ~sel_q;
    assign pause_e = btn_pause  & ~pause_q;

    always_comb begin
        nxt_state     = state;
        nxt_fcnt      = fcnt;
        nxt_cursor    = cursor;
        nxt_song_sel  = song_sel;
        nxt_countdown = countdown;
        nxt_start     = 1'b0;
        nxt_quit      = 1'b0;

        case (state)
            ST_MAIN: begin
                // btn_pause has no meaning here, so it does not mask up/down.
                if (sel_e) begin
                    nxt_song_sel  = cursor;
                    nxt_start     = 1'b1;
                    nxt_state     = ST_COUNTDOWN;
                    nxt_countdown = 2'd3;
                    nxt_fcnt      = '0;
                end else if (up_e) begin
                    nxt_cursor = (cursor == 2'd0) ? LAST_SONG : cursor - 2'd1;
                end else if (down_e) begin
                    nxt_cursor = (cursor >= LAST_SONG) ? 2'd0 : cursor + 2'd1;
                end
            end

            ST_COUNTDOWN: begin
                if (frame_tick) begin
                    if (fcnt == FRAME_LAST) begin
                        nxt_fcnt = '0;
                        if (countdown == 2'd1) begin
                            nxt_state     = ST_PLAYING;
                            nxt_countdown = 2'd0;
                        end else begin
                            nxt_countdown = countdown - 2'd1;
                        end
                    end else begin
                        nxt_fcnt = fcnt + 1'b1;
                    end
                end
            end

            ST_PLAYING: begin
                // A finished song wins over a pause press in the same cycle;
                // there is nothing left to pause.
                if (song_done) begin
                    nxt_state  = ST_MAIN;
                    nxt_cursor = song_sel;
                end else if (pause_e) begin
                    nxt_state  = ST_PAUSED;
                    nxt_cursor = 2'd0;
                end
            end

            default: begin // ST_PAUSED
                if (sel_e) begin
                    if (cursor == 2'd0) begin
                        nxt_state     = ST_COUNTDOWN;
                        nxt_countdown = 2'd3;
                        nxt_fcnt      = '0;
                    end else begin
                        nxt_quit   = 1'b1;
                        nxt_state  = ST_MAIN;
                        nxt_cursor = song_sel;
                    end
                end else if (pause_e) begin
                    nxt_state     = ST_COUNTDOWN;
                    nxt_countdown = 2'd3;
                    nxt_fcnt      = '0;
                end else if (up_e) begin
                    nxt_cursor = (cursor == 2'd0) ? 2'd1 : 2'd0;
                end else if (down_e) begin
                    nxt_cursor = (cursor >= 2'd1) ? 2'd0 : 2'd1;
                end
            end
        endcase
    end

    // Level outputs are decoded from the next state so they change on the
    // same edge as the state register.
    always_ff @(posedge clk65) begin
        if (reset) begin
            state       <= ST_MAIN;
            fcnt        <= '0;
            up_q        <= 1'b0;
            down_q      <= 1'b0;
            sel_q       <= 1'b0;
            pause_q     <= 1'b0;
            pause       <= 1'b1;
            menu_page   <= 1'b0;
            cursor      <= 2'd0;
            song_sel    <= 2'd0;
            game_run    <= 1'b0;
            countdown   <= 2'd0;
            start_pulse <= 1'b0;
            quit_pulse  <= 1'b0;
        end else begin
            up_q        <= btn_up;
            down_q      <= btn_down;
            sel_q       <= btn_select;
            pause_q     <= btn_pause;
            state       <= nxt_state;
            fcnt        <= nxt_fcnt;
            cursor      <= nxt_cursor;
            song_sel    <= nxt_song_sel;
            countdown   <= nxt_countdown;
            start_pulse <= nxt_start;
            quit_pulse  <= nxt_quit;
            pause       <= (nxt_state == ST_MAIN) || (nxt_state == ST_PAUSED);
            menu_page   <= (nxt_state == ST_PAUSED);
            game_run    <= (nxt_state == ST_PLAYING);
        end
    end

endmodule
